// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiplier command sequencer.
// The timeout feature is enabled by defining MATMUL_CTRL_TIMEOUT_EN.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    WRITE,
    DONE
  } ctrl_state_t;

  localparam int DIM_W  = 2;
  localparam int A_BASE = 0;

  function automatic int calc_max_dim(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  // B rows sit directly after the A rows in operand memory.
  function automatic int calc_b_base(input int max_dim);
    return A_BASE + max_dim;
  endfunction

  function automatic int calc_timeout(input int max_dim);
    return 4 * (3 * max_dim + 2);
  endfunction

  localparam int MAX_DIM       = calc_max_dim(16, 8);
  localparam int B_BASE        = calc_b_base(MAX_DIM);
  localparam int TIMEOUT_LIMIT = calc_timeout(MAX_DIM);

endpackage

// File: rtl/matmul_operand_loader.sv
// Streams A then B rows from operand memory into the flat operand registers,
// aligning the one-cycle read latency and zeroing rows/elements beyond the dims.
module matmul_operand_loader
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 4,
  localparam int MAX_DIM_L = calc_max_dim(BUS_WIDTH, DATA_WIDTH)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear,
  input  logic                              active,
  input  logic [DIM_W-1:0]                  n_dim,
  input  logic [DIM_W-1:0]                  k_dim,
  input  logic [DIM_W-1:0]                  m_dim,
  output logic                              op_rd_o,
  output logic [ADDR_WIDTH-1:0]             op_addr_o,
  input  logic [BUS_WIDTH-1:0]              op_data_i,
  output logic [MAX_DIM_L*BUS_WIDTH-1:0]    a_matrix,
  output logic [MAX_DIM_L*BUS_WIDTH-1:0]    b_matrix,
  output logic                              load_done
);

  localparam int N_READS = 2 * MAX_DIM_L;
  localparam int CNT_W   = $clog2(N_READS + 1);
  localparam int B_ADDR  = calc_b_base(MAX_DIM_L);

  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     idx_q;
  logic                 rd_q;
  logic                 is_b;
  int                   row;
  int                   row_lim;
  int                   elem_lim;
  logic [BUS_WIDTH-1:0] masked;

  assign op_rd_o   = active && (int'(cnt) < N_READS);
  assign load_done = active && (int'(cnt) == N_READS);

  always_comb begin
    op_addr_o = '0;
    if (op_rd_o) begin
      if (int'(cnt) < MAX_DIM_L) op_addr_o = ADDR_WIDTH'(A_BASE + int'(cnt));
      else                       op_addr_o = ADDR_WIDTH'(B_ADDR + int'(cnt) - MAX_DIM_L);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt   <= '0;
      rd_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      cnt   <= active ? cnt + CNT_W'(1) : '0;
      rd_q  <= op_rd_o;
      idx_q <= cnt;
    end
  end

  // idx_q names the row whose data is on the bus this cycle.
  always_comb begin
    is_b     = int'(idx_q) >= MAX_DIM_L;
    row      = is_b ? int'(idx_q) - MAX_DIM_L : int'(idx_q);
    row_lim  = is_b ? int'(k_dim) : int'(n_dim);
    elem_lim = is_b ? int'(m_dim) : int'(k_dim);
    masked   = '0;
    for (int e = 0; e < MAX_DIM_L; e++) begin
      if (row <= row_lim && e <= elem_lim)
        masked[e*DATA_WIDTH +: DATA_WIDTH] = op_data_i[e*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_matrix <= '0;
      b_matrix <= '0;
    end else if (clear) begin
      a_matrix <= '0;
      b_matrix <= '0;
    end else if (rd_q) begin
      for (int r = 0; r < MAX_DIM_L; r++) begin
        if (row == r) begin
          if (is_b) b_matrix[r*BUS_WIDTH +: BUS_WIDTH] <= masked;
          else      a_matrix[r*BUS_WIDTH +: BUS_WIDTH] <= masked;
        end
      end
    end
  end

endmodule

// File: rtl/matmul_ctrl.sv
// Command sequencer for the systolic multiplier: load operands, run, write back.
// Define MATMUL_CTRL_TIMEOUT_EN to abort a COMPUTE phase that never finishes.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 16,
  parameter int SP_NTARGETS = 4,
  parameter int ADDR_WIDTH  = 4,
  localparam int MAX_DIM_L  = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int SEL_W      = $clog2(SP_NTARGETS)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  cmd_start_i,
  input  logic                                  cmd_mode_i,
  input  logic [DIM_W-1:0]                      cmd_n_dim_i,
  input  logic [DIM_W-1:0]                      cmd_k_dim_i,
  input  logic [DIM_W-1:0]                      cmd_m_dim_i,
  input  logic [SEL_W-1:0]                      cmd_sp_sel_i,
  output logic                                  op_rd_o,
  output logic [ADDR_WIDTH-1:0]                 op_addr_o,
  input  logic [BUS_WIDTH-1:0]                  op_data_i,
  output logic [MAX_DIM_L*MAX_DIM_L*DATA_WIDTH-1:0] a_matrix_o,
  output logic [MAX_DIM_L*MAX_DIM_L*DATA_WIDTH-1:0] b_matrix_o,
  output logic [DIM_W-1:0]                      n_dim_o,
  output logic [DIM_W-1:0]                      k_dim_o,
  output logic [DIM_W-1:0]                      m_dim_o,
  output logic                                  mode_bit_o,
  output logic                                  mul_start_o,
  input  logic                                  mul_finish_i,
  input  logic [MAX_DIM_L*MAX_DIM_L-1:0]        mul_flags_i,
  output logic                                  finish_write_o,
  output logic [SEL_W-1:0]                      sp_sel_o,
  output logic                                  sp_wr_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [MAX_DIM_L*MAX_DIM_L-1:0]        flags_o,
  output logic                                  err_o
);

  ctrl_state_t state, next_state;
  logic        accept;
  logic        load_done;
  logic        timeout_hit;

  assign accept = (state == IDLE) && cmd_start_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state     = state;
    mul_start_o    = 1'b0;
    sp_wr_o        = 1'b0;
    finish_write_o = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    case (state)
      IDLE: if (cmd_start_i) next_state = LOAD;
      LOAD: begin
        busy_o = 1'b1;
        if (load_done) next_state = COMPUTE;
      end
      COMPUTE: begin
        busy_o      = 1'b1;
        mul_start_o = 1'b1;
        if (mul_finish_i)     next_state = WRITE;
        else if (timeout_hit) next_state = DONE;
      end
      WRITE: begin
        busy_o         = 1'b1;
        mul_start_o    = 1'b1;
        sp_wr_o        = 1'b1;
        finish_write_o = 1'b1;
        next_state     = DONE;
      end
      DONE: begin
        done_o     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Command fields stay latched after completion; flags are sticky until the next command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_dim_o    <= '0;
      k_dim_o    <= '0;
      m_dim_o    <= '0;
      mode_bit_o <= 1'b0;
      sp_sel_o   <= '0;
      flags_o    <= '0;
    end else if (accept) begin
      n_dim_o    <= cmd_n_dim_i;
      k_dim_o    <= cmd_k_dim_i;
      m_dim_o    <= cmd_m_dim_i;
      mode_bit_o <= cmd_mode_i;
      sp_sel_o   <= cmd_sp_sel_i;
      flags_o    <= '0;
    end else if (state == WRITE) begin
      flags_o <= mul_flags_i;
    end
  end

  matmul_operand_loader #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUS_WIDTH (BUS_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_loader (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear    (accept),
    .active   (state == LOAD),
    .n_dim    (n_dim_o),
    .k_dim    (k_dim_o),
    .m_dim    (m_dim_o),
    .op_rd_o  (op_rd_o),
    .op_addr_o(op_addr_o),
    .op_data_i(op_data_i),
    .a_matrix (a_matrix_o),
    .b_matrix (b_matrix_o),
    .load_done(load_done)
  );

`ifdef MATMUL_CTRL_TIMEOUT_EN
  localparam int TO_LIMIT = calc_timeout(MAX_DIM_L);
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [TO_W-1:0] compute_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 compute_cnt <= '0;
    else if (state == COMPUTE)   compute_cnt <= compute_cnt + TO_W'(1);
    else                         compute_cnt <= '0;
  end

  assign timeout_hit = (state == COMPUTE) && !mul_finish_i &&
                       (int'(compute_cnt) == TO_LIMIT - 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          err_o <= 1'b0;
    else if (accept)      err_o <= 1'b0;
    else if (timeout_hit) err_o <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Randomized self-checking bench for matmul_ctrl against a behavioural model
// of operand loading, command timing and write-back.
module tb_matmul_ctrl;

`ifdef MATMUL_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_CYCLES = 32;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_start_i = 1'b0;
  logic        cmd_mode_i = 1'b0;
  logic [1:0]  cmd_n_dim_i = '0, cmd_k_dim_i = '0, cmd_m_dim_i = '0;
  logic [1:0]  cmd_sp_sel_i = '0;
  logic        op_rd_o;
  logic [3:0]  op_addr_o;
  logic [15:0] op_data_i = '0;
  logic [31:0] a_matrix_o, b_matrix_o;
  logic [1:0]  n_dim_o, k_dim_o, m_dim_o;
  logic        mode_bit_o, mul_start_o;
  logic        mul_finish_i = 1'b0;
  logic [3:0]  mul_flags_i = '0;
  logic        finish_write_o;
  logic [1:0]  sp_sel_o;
  logic        sp_wr_o, busy_o, done_o;
  logic [3:0]  flags_o;
  logic        err_o;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [16];
  logic [15:0] pend = '0;
  logic        pend_valid = 1'b0;
  int          read_log [$];

  matmul_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_start_i(cmd_start_i), .cmd_mode_i(cmd_mode_i),
    .cmd_n_dim_i(cmd_n_dim_i), .cmd_k_dim_i(cmd_k_dim_i), .cmd_m_dim_i(cmd_m_dim_i),
    .cmd_sp_sel_i(cmd_sp_sel_i), .op_rd_o(op_rd_o), .op_addr_o(op_addr_o),
    .op_data_i(op_data_i), .a_matrix_o(a_matrix_o), .b_matrix_o(b_matrix_o),
    .n_dim_o(n_dim_o), .k_dim_o(k_dim_o), .m_dim_o(m_dim_o), .mode_bit_o(mode_bit_o),
    .mul_start_o(mul_start_o), .mul_finish_i(mul_finish_i), .mul_flags_i(mul_flags_i),
    .finish_write_o(finish_write_o), .sp_sel_o(sp_sel_o), .sp_wr_o(sp_wr_o),
    .busy_o(busy_o), .done_o(done_o), .flags_o(flags_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Operand memory: data for a read appears one cycle later, garbage otherwise.
  always @(negedge clk_i) begin
    op_data_i  = pend_valid ? pend : 16'($urandom);
    pend_valid = op_rd_o;
    pend       = mem[op_addr_o];
    if (op_rd_o) read_log.push_back(int'(op_addr_o));
  end

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] ctrl_bits();
    return {op_rd_o, op_addr_o, n_dim_o, k_dim_o, m_dim_o, mode_bit_o, mul_start_o,
            finish_write_o, sp_sel_o, sp_wr_o, busy_o, done_o, flags_o, err_o};
  endfunction

  // Element (r,e) of A is mem[r] element e when r<=n and e<=k; B likewise from mem[2+r].
  function automatic logic [31:0] model_matrix(input bit is_b, input int row_lim, input int elem_lim);
    logic [31:0] res = '0;
    logic [15:0] word;
    for (int r = 0; r < 2; r++) begin
      word = mem[(is_b ? 2 : 0) + r];
      for (int e = 0; e < 2; e++)
        if (r <= row_lim && e <= elem_lim) res[r*16 + e*8 +: 8] = word[e*8 +: 8];
    end
    return res;
  endfunction

  task automatic fill_random_mem();
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
  endtask

  task automatic run_cmd(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m,
                         input logic mode, input logic [1:0] sel, input int t_mul,
                         input logic [3:0] flags, input bit extra_start, input bit done_start);
    int c = 0, first_start = -1, done_cyc = -1, wr_cyc = -1;
    int n_done = 0, n_wr = 0, n_busy = 0, n_start = 0, n_modebad = 0, n_fwbad = 0;
    logic [1:0] sel_at_wr = '0;
    bit expect_to;
    expect_to = TO_EN && (t_mul > TO_CYCLES);
    read_log.delete();
    @(negedge clk_i);
    cmd_n_dim_i = n; cmd_k_dim_i = k; cmd_m_dim_i = m;
    cmd_mode_i = mode; cmd_sp_sel_i = sel; cmd_start_i = 1'b1; mul_flags_i = flags;
    while (c < 200 && !(done_cyc >= 0 && c >= done_cyc + 2)) begin
      @(negedge clk_i);
      c++;
      cmd_start_i = 1'b0;
      mul_finish_i = 1'b0;
      if (c == 1) begin
        check_output("flags_cleared", flags_o, 0);
        check_output("err_cleared", err_o, 0);
        check_output("a_cleared", a_matrix_o, 0);
      end
      if (busy_o) n_busy++;
      if (mul_start_o) begin
        n_start++;
        if (first_start < 0) first_start = c;
      end
      if (mode_bit_o !== mode) n_modebad++;
      if (finish_write_o !== sp_wr_o) n_fwbad++;
      if (sp_wr_o) begin n_wr++; wr_cyc = c; sel_at_wr = sp_sel_o; end
      if (done_o) begin
        n_done++; done_cyc = c;
        if (done_start) cmd_start_i = 1'b1;
      end
      if (c == 2) mul_finish_i = 1'b1;
      if (c - 5 == t_mul) mul_finish_i = 1'b1;
      if (extra_start && c - 5 == 2) begin
        cmd_start_i = 1'b1; cmd_n_dim_i = ~n; cmd_k_dim_i = ~k; cmd_m_dim_i = ~m;
        cmd_mode_i = ~mode; cmd_sp_sel_i = sel + 2'd1;
      end
    end
    check_output("read_count", read_log.size(), 4);
    for (int i = 0; i < read_log.size() && i < 4; i++) check_output("read_addr", read_log[i], i);
    check_output("a_matrix", a_matrix_o, model_matrix(1'b0, int'(n), int'(k)));
    check_output("b_matrix", b_matrix_o, model_matrix(1'b1, int'(k), int'(m)));
    check_output("dims", {n_dim_o, k_dim_o, m_dim_o}, {n, k, m});
    check_output("mode_steady", n_modebad, 0);
    check_output("fw_eq_spwr", n_fwbad, 0);
    check_output("start_first", first_start, 6);
    check_output("done_count", n_done, 1);
    if (expect_to) begin
      check_output("start_cycles", n_start, TO_CYCLES);
      check_output("done_cycle", done_cyc, 6 + TO_CYCLES);
      check_output("busy_cycles", n_busy, 5 + TO_CYCLES);
      check_output("wr_count", n_wr, 0);
      check_output("flags", flags_o, 0);
      check_output("err", err_o, 1);
    end else begin
      check_output("start_cycles", n_start, t_mul + 1);
      check_output("done_cycle", done_cyc, 7 + t_mul);
      check_output("busy_cycles", n_busy, 6 + t_mul);
      check_output("wr_count", n_wr, 1);
      check_output("wr_cycle", wr_cyc, 6 + t_mul);
      check_output("wr_sel", sel_at_wr, sel);
      check_output("flags", flags_o, flags);
      check_output("err", err_o, 0);
    end
    mul_flags_i = '0;
  endtask

  task automatic apply_stimulus();
    int n_bad = 0;
    // Reset state.
    repeat (2) @(negedge clk_i);
    check_output("reset_ctrl", ctrl_bits(), 0);
    check_output("reset_mat", {a_matrix_o, b_matrix_o}, 0);
    rst_ni = 1'b1;

    // Full 2x2x2 with fixed memory.
    fill_random_mem();
    mem[0] = 16'h0201; mem[1] = 16'h0403; mem[2] = 16'h0605; mem[3] = 16'h0807;
    run_cmd(2'd1, 2'd1, 2'd1, 1'b0, 2'd2, 6, 4'b0000, 1'b0, 1'b0);
    check_output("a_full_const", a_matrix_o, 32'h04030201);
    check_output("b_full_const", b_matrix_o, 32'h08070605);

    // 1x1x1 masking on the same memory.
    run_cmd(2'd0, 2'd0, 2'd0, 1'b0, 2'd1, 3, 4'b0000, 1'b0, 1'b0);
    check_output("a_min_const", a_matrix_o, 32'h00000001);
    check_output("b_min_const", b_matrix_o, 32'h00000005);

    // Accumulate with flags, then a command that must clear them.
    fill_random_mem();
    run_cmd(2'd1, 2'd0, 2'd1, 1'b1, 2'd3, 4, 4'b0100, 1'b0, 1'b1);
    fill_random_mem();
    run_cmd(2'd0, 2'd1, 2'd1, 1'b0, 2'd0, 2, 4'b1001, 1'b1, 1'b0);

    // Reset in the middle of LOAD.
    fill_random_mem();
    @(negedge clk_i);
    cmd_n_dim_i = 2'd1; cmd_k_dim_i = 2'd1; cmd_m_dim_i = 2'd1;
    cmd_mode_i = 1'b1; cmd_sp_sel_i = 2'd3; cmd_start_i = 1'b1;
    @(negedge clk_i); cmd_start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_output("midreset_ctrl", ctrl_bits(), 0);
    check_output("midreset_mat", {a_matrix_o, b_matrix_o}, 0);
    repeat (3) begin
      @(negedge clk_i);
      if (sp_wr_o || done_o) n_bad++;
    end
    check_output("midreset_quiet", n_bad, 0);
    rst_ni = 1'b1;
    run_cmd(2'd1, 2'd1, 2'd0, 1'b0, 2'd2, 5, 4'b0010, 1'b0, 1'b0);

    // Long compute: aborts when the timeout is built in, completes otherwise.
    fill_random_mem();
    run_cmd(2'd1, 2'd1, 2'd1, 1'b1, 2'd1, 40, 4'b1111, 1'b0, 1'b0);
    run_cmd(2'd1, 2'd0, 2'd0, 1'b0, 2'd0, 1, 4'b0001, 1'b0, 1'b0);

    // Randomized commands.
    for (int i = 0; i < 8; i++) begin
      fill_random_mem();
      run_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom), 2'($urandom), int'($urandom_range(1, 10)), 4'($urandom),
              1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    $display("[TB] starting matmul_ctrl bench");
    apply_stimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
Name: matmul_ctrl

Overview:
- Command sequencer for the systolic matrix multiplier. Accepts one command (dims, accumulate mode, scratchpad target) from the register file.
- Fetches operand rows of A and B from operand memory into the multiplier's flat A/B input registers.
- Drives the multiplier start level until finish. Issues the scratchpad write of the result, latches overflow flags, and reports done/busy.
- Sits between the register file / operand memory and the multiplier + scratchpad.

Parameters:
- DATA_WIDTH, 8, operand element width.
- BUS_WIDTH, 16, bus word width; one operand row = one bus word.
- SP_NTARGETS, 4, number of scratchpad result slots.
- ADDR_WIDTH, 4, operand memory address width.
- Derived localparam: MAX_DIM = BUS_WIDTH/DATA_WIDTH.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- cmd_start_i  in  1  one-cycle command pulse from register file
- cmd_mode_i  in  1  1 = accumulate with scratchpad C
- cmd_n_dim_i / cmd_k_dim_i / cmd_m_dim_i  in  2 each  dims minus 1 (value d = d+1 elements)
- cmd_sp_sel_i  in  $clog2(SP_NTARGETS)  scratchpad slot for C read and result write
- op_rd_o  out  1  operand memory read strobe
- op_addr_o  out  ADDR_WIDTH  read address
- op_data_i  in  BUS_WIDTH  read data, valid exactly 1 cycle after op_rd_o
- a_matrix_o / b_matrix_o  out  MAX_DIM*MAX_DIM*DATA_WIDTH  flat operand registers to multiplier
- n_dim_o / k_dim_o / m_dim_o  out  2 each  latched dims to multiplier
- mode_bit_o  out  1  latched mode to multiplier
- mul_start_o  out  1  multiplier start level
- mul_finish_i  in  1  multiplier finish
- mul_flags_i  in  MAX_DIM*MAX_DIM  multiplier overflow flags
- finish_write_o  out  1  multiplier finish_write pulse
- sp_sel_o  out  $clog2(SP_NTARGETS)  scratchpad slot (C read / result write)
- sp_wr_o  out  1  scratchpad write strobe
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle completion pulse
- flags_o  out  MAX_DIM*MAX_DIM  sticky overflow flags of last command
- err_o  out  1  timeout error (feature only; tied 0 otherwise)

Behaviour:
- Reset values: all outputs and registers 0. FSM goes to IDLE. Reset mid-operation aborts immediately, with no write and no done.
- FSM states: IDLE, LOAD, COMPUTE, WRITE, DONE.
- IDLE:
  - On cmd_start_i, latch dims, mode and sp_sel into their outputs. Clear flags_o and a/b_matrix_o.
  - busy_o=1 from the next cycle. Next state LOAD.
- cmd_start_i outside IDLE is ignored, with no queuing.
- LOAD: issue 2*MAX_DIM reads on consecutive cycles, one read per cycle.
  - Addresses 0..MAX_DIM-1 are A rows 0..MAX_DIM-1; addresses MAX_DIM..2*MAX_DIM-1 are B rows.
  - Capture each word 1 cycle later into row r of a/b_matrix_o. Row r occupies bits [r*BUS_WIDTH +: BUS_WIDTH], element e within it occupies [e*DATA_WIDTH +: DATA_WIDTH].
  - Masking: A row r>n_dim and A elements e>k_dim are written 0. B row r>k_dim and B elements e>m_dim are written 0.
  - LOAD lasts 2*MAX_DIM+1 cycles (5 for defaults). Then COMPUTE.
- COMPUTE: mul_start_o=1, held high until mul_finish_i is seen. No upper bound without the optional feature.
- WRITE (1 cycle):
  - mul_start_o stays 1; sp_wr_o=1; finish_write_o=1.
  - flags_o <= mul_flags_i, sticky until the next accepted command.
- DONE (1 cycle): mul_start_o=0, done_o=1, busy_o=0. Then IDLE. A cmd_start_i in DONE is ignored.
- Total latency from cmd_start_i to done_o = 1 + (2*MAX_DIM+1) + T_mul + 2 cycles.
- mul_finish_i while not in COMPUTE is ignored.

Optional Feature:
- Macro MATMUL_CTRL_TIMEOUT_EN.
- Defined:
  - A COMPUTE-cycle counter aborts when it reaches 4*(3*MAX_DIM+2) without mul_finish_i.
  - Abort: mul_start_o drops, no sp_wr_o/finish_write_o, err_o=1 sticky until next accepted command, done_o pulses. Then IDLE.
- Undefined: no counter; err_o tied 0.

Decomposition:
- Shared package matmul_pkg:
  - FSM state typedef.
  - MAX_DIM computation.
  - Dim field width (2).
  - Operand memory base-address constants (A_BASE=0, B_BASE=MAX_DIM).
  - Timeout limit constant.
- One natural sub-module: matmul_operand_loader. It owns the LOAD read counter, address generation, 1-cycle data alignment and masking. It reports load_done to the FSM.

Test Plan:
- Full 2x2x2, mode 0, sp_sel 2. Memory: A rows {0x0201, 0x0403}, B rows {0x0605, 0x0807}.
  - Expect 4 reads at addresses 0,1,2,3.
  - a_matrix_o=0x04030201, b_matrix_o=0x08070605.
  - mul_start_o high from cycle 7.
  - Model finish after 6 cycles: sp_wr_o with sp_sel_o=2, then done_o.
- Dims n=0, k=0, m=0, same memory: a_matrix_o=0x00000001, b_matrix_o=0x00000005.
- Accumulate: mode 1 latched, mode_bit_o=1 throughout. Model flags_i=4'b0100 at finish → flags_o=4'b0100 after WRITE. Flags clear on the next command.
- cmd_start_i pulsed again during COMPUTE: no effect, with a single done_o only.
- rst_ni low mid-LOAD: all outputs 0 next edge with no sp_wr_o. A new command afterwards completes normally.
- With MATMUL_CTRL_TIMEOUT_EN and finish never asserted: abort after 32 COMPUTE cycles, err_o=1, done_o pulse, no sp_wr_o.
